// File: rtl/conv3x3_mac.sv
// 3x3 convolution multiply-accumulate engine behind an Avalon-MM slave register file.
// Define CONV_RELU_EN to clamp negative results to zero when they are latched into RESULT.
module conv3x3_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W+5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  avs_address,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    input  logic        avs_read,
    output logic [31:0] avs_readdata,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [4:0] ADDR_CTRL   = 5'h12;
    localparam logic [4:0] ADDR_STATUS = 5'h13;
    localparam logic [4:0] ADDR_RESULT = 5'h14;

    state_t                    state;
    logic signed [DATA_W-1:0]  k_reg [9];
    logic        [DATA_W-1:0]  p_reg [9];
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   result;
    logic        [3:0]         idx;
    logic                      done;
    logic                      irq_en;

    logic signed [2*DATA_W:0]  product;
    logic signed [ACC_W-1:0]   acc_next;
    logic signed [ACC_W-1:0]   result_next;
    logic        [31:0]        rd_data;
    logic                      ctrl_wr;
    logic                      kp_wr_ok;
    logic                      unused_wdata;

    assign ctrl_wr      = avs_write && (avs_address == ADDR_CTRL);
    assign kp_wr_ok     = avs_write && (state != RUN);
    assign irq          = done & irq_en;
    assign unused_wdata = ^avs_writedata[31:DATA_W];

    // Pixel is zero-extended by one bit so the multiply stays fully signed.
    always_comb begin
        product     = $signed({1'b0, p_reg[idx]}) * k_reg[idx];
        acc_next    = acc + {{(ACC_W-2*DATA_W-1){product[2*DATA_W]}}, product};
        result_next = acc_next;
`ifdef CONV_RELU_EN
        if (acc_next[ACC_W-1]) begin
            result_next = '0;
        end
`endif
    end

    always_comb begin
        rd_data = '0;
        if (avs_address < 5'd9) begin
            rd_data = {{(32-DATA_W){k_reg[avs_address[3:0]][DATA_W-1]}}, k_reg[avs_address[3:0]]};
        end else if (avs_address < 5'd18) begin
            rd_data = {{(32-DATA_W){1'b0}}, p_reg[4'(avs_address - 5'd9)]};
        end else if (avs_address == ADDR_CTRL) begin
            rd_data = {30'd0, irq_en, 1'b0};
        end else if (avs_address == ADDR_STATUS) begin
            rd_data = {30'd0, done, state == RUN};
        end else if (avs_address == ADDR_RESULT) begin
            rd_data = {{(32-ACC_W){result[ACC_W-1]}}, result};
        end
    end

    // Register file, sequencer and read port share one clocked process so reset clears everything together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            acc          <= '0;
            result       <= '0;
            idx          <= '0;
            done         <= 1'b0;
            irq_en       <= 1'b0;
            avs_readdata <= '0;
            for (int i = 0; i < 9; i++) begin
                k_reg[i] <= '0;
                p_reg[i] <= '0;
            end
        end else begin
            if (avs_read) begin
                avs_readdata <= rd_data;
            end

            if (ctrl_wr) begin
                irq_en <= avs_writedata[1];
                if (avs_writedata[2]) begin
                    done <= 1'b0;
                end
            end

            if (kp_wr_ok && avs_address < 5'd9) begin
                k_reg[avs_address[3:0]] <= avs_writedata[DATA_W-1:0];
            end else if (kp_wr_ok && avs_address < 5'd18) begin
                p_reg[4'(avs_address - 5'd9)] <= avs_writedata[DATA_W-1:0];
            end

            case (state)
                IDLE: begin
                    if (ctrl_wr && avs_writedata[0]) begin
                        state <= RUN;
                        acc   <= '0;
                        idx   <= '0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    idx <= idx + 4'd1;
                    if (idx == 4'd8) begin
                        result <= result_next;
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Randomized self-checking bench for conv3x3_mac against a plain-arithmetic convolution model.
// Honours CONV_RELU_EN in the model so it can check either build.
module tb_conv3x3_mac;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  avs_address;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_k [9];
    logic [7:0] model_p [9];
    logic       model_irq_en;

    always #5 clk = ~clk;

    conv3x3_mac dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
        end
    endtask

    // All bus tasks are entered and left at a falling edge; each consumes one cycle.
    task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    function automatic logic [31:0] model_result();
        int sum = 0;
        for (int i = 0; i < 9; i++) begin
            sum += int'($signed(model_k[i])) * int'(model_p[i]);
        end
`ifdef CONV_RELU_EN
        if (sum < 0) sum = 0;
`endif
        return 32'(sum);
    endfunction

    function automatic logic [31:0] model_k_read(input int i);
        return 32'(int'($signed(model_k[i])));
    endfunction

    task automatic applyStimulus();
        logic [31:0] junk;
        for (int i = 0; i < 9; i++) begin
            junk = $urandom();
            write_reg(5'(i), {junk[31:8], model_k[i]});
            junk = $urandom();
            write_reg(5'(i + 9), {junk[31:8], model_p[i]});
        end
    endtask

    task automatic randomize_model();
        for (int i = 0; i < 9; i++) begin
            model_k[i] = 8'($urandom_range(0, 255));
            model_p[i] = 8'($urandom_range(0, 255));
        end
    endtask

    // Start from IDLE and check STATUS cycle by cycle, then irq and RESULT.
    task automatic run_and_check(input string tag, input logic [31:0] ctrl_val);
        logic [31:0] d;
        model_irq_en = ctrl_val[1];
        write_reg(5'h12, ctrl_val);
        for (int j = 1; j <= 11; j++) begin
            read_reg(5'h13, d);
            checkOutput($sformatf("%s status@N+%0d", tag, j), d, (j <= 9) ? 32'd1 : 32'd2);
        end
        checkOutput({tag, " irq"}, {31'd0, irq}, {31'd0, model_irq_en});
        read_reg(5'h14, d);
        checkOutput({tag, " result"}, d, model_result());
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d = '0;
        for (int n = 0; n < 30; n++) begin
            read_reg(5'h13, d);
            if (d[1]) break;
        end
        checkOutput({tag, " done reached"}, {31'd0, d[1]}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int          sel;
        int          n;

        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        int          sel;

        reset_n       = 1'b0;
        avs_address   = '0;
        avs_write     = 1'b0;
        avs_writedata = '0;
        avs_read      = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset readdata", avs_readdata, 32'd0);
        checkOutput("reset irq", {31'd0, irq}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        read_reg(5'h13, d); checkOutput("reset status", d, 32'd0);
        read_reg(5'h14, d); checkOutput("reset result", d, 32'd0);
        read_reg(5'h00, d); checkOutput("reset k0", d, 32'd0);
        read_reg(5'h11, d); checkOutput("reset p8", d, 32'd0);
        read_reg(5'h12, d); checkOutput("reset ctrl", d, 32'd0);

        for (int i = 0; i < 9; i++) begin
            model_k[i] = 8'd1;
            model_p[i] = 8'(i + 1);
        end
        applyStimulus();
        run_and_check("ones", 32'h3);

        for (int i = 0; i < 9; i++) begin
            model_k[i] = 8'hFF;
            model_p[i] = 8'hFF;
        end
        applyStimulus();
        read_reg(5'h00, d); checkOutput("k0 sign-extend", d, 32'hFFFF_FFFF);
        read_reg(5'h09, d); checkOutput("p0 zero-extend", d, 32'h0000_00FF);
        run_and_check("minus1", 32'h1);

        for (int i = 0; i < 9; i++) begin
            model_k[i] = 8'h80;
            model_p[i] = 8'hFF;
        end
        applyStimulus();
        run_and_check("extreme", 32'h1);

        read_reg(5'h13, d); checkOutput("done held", d, 32'd2);
        randomize_model();
        applyStimulus();
        read_reg(5'h13, d); checkOutput("done held after writes", d, 32'd2);
        run_and_check("start+clr", 32'h5);

        write_reg(5'h12, 32'h4);
        read_reg(5'h13, d); checkOutput("clr_done status", d, 32'd0);
        checkOutput("clr_done irq", {31'd0, irq}, 32'd0);

        // Mid-run start and P0 writes must both be ignored.
        randomize_model();
        applyStimulus();
        write_reg(5'h12, 32'h1);
        repeat (2) @(negedge clk);
        write_reg(5'h12, 32'h1);
        write_reg(5'h09, {24'd0, ~model_p[0]});
        wait_done("busy-ignore");
        read_reg(5'h14, d); checkOutput("busy-ignore result", d, model_result());
        read_reg(5'h09, d); checkOutput("busy-ignore p0", d, {24'd0, model_p[0]});

        // Reset in cycle N+5 of a run.
        randomize_model();
        applyStimulus();
        write_reg(5'h12, 32'h3);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        checkOutput("midrun reset irq", {31'd0, irq}, 32'd0);
        read_reg(5'h13, d); checkOutput("midrun reset status", d, 32'd0);
        read_reg(5'h14, d); checkOutput("midrun reset result", d, 32'd0);
        read_reg(5'h04, d); checkOutput("midrun reset k4", d, 32'd0);
        randomize_model();
        applyStimulus();
        run_and_check("after reset", 32'h3);

        write_reg(5'h1F, 32'hDEAD_BEEF);
        read_reg(5'h1F, d); checkOutput("unmapped read", d, 32'd0);
        read_reg(5'h15, d); checkOutput("unmapped 0x15 read", d, 32'd0);

        for (int r = 0; r < 6; r++) begin
            randomize_model();
            applyStimulus();
            sel = $urandom_range(0, 8);
            read_reg(5'(sel), d);
            checkOutput($sformatf("rand%0d k%0d", r, sel), d, model_k_read(sel));
            read_reg(5'(sel + 9), d);
            checkOutput($sformatf("rand%0d p%0d", r, sel), d, {24'd0, model_p[sel]});
            run_and_check($sformatf("rand%0d", r), {29'd0, 1'b1, 1'($urandom_range(0, 1)), 1'b1});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
